mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL declare parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL declare parameter CNT_W, default 5, iteration counter width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  issue request, sampled only in IDLE.
REQ-006 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 srcA, srcB  input  WIDTH  rs/rt operands (dividend/divisor for DIV*).
REQ-008 flush  input  1  abort in-flight op (pipeline kill).
REQ-009 wrLo, wrHi, wrData  input  1,1,WIDTH  MTLO/MTHI write port.
REQ-010 busy  output  1  op in flight; EX stage stalls on HI/LO use.
REQ-011 done  output  1  one-cycle pulse: new hi/lo committed this cycle.
REQ-012 writeLoHi  output  1  equals done; HI/LO-producer flag for the forwarding path.
REQ-013 lo, hi  output  WIDTH  architectural LO/HI register values.

Function
REQ-014 FSM states: IDLE, CALC, FIX, DONE.
REQ-015 IDLE & start -> CALC; operands latched as magnitudes (signed ops) plus result-sign flags; counter=0.
REQ-016 CALC: one radix-2 step per cycle (shift-add multiply, restoring divide); counter increments; exits to FIX after step WIDTH-1 (32 cycles).
REQ-017 FIX: two's-complement sign correction; quotient negated iff operand signs differ, remainder takes dividend sign, product negated iff signs differ.
REQ-018 FIX -> DONE: hi/lo registers load results on this edge; done=1 for the single DONE cycle; DONE -> IDLE unconditionally.
REQ-019 Latency: start sampled at edge E0; done high in the cycle following edge E0+34; hi/lo show new values that same cycle.
REQ-020 busy=1 in CALC and FIX; busy=0 in IDLE and DONE.
REQ-021 Multiply: hi:lo = full 2*WIDTH product.
REQ-022 Divide: lo=quotient, hi=remainder.
REQ-023 Divide by zero: lo=all-ones, hi=srcA, full 34-cycle latency, no exception.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-025 start while not IDLE: ignored, no queuing.
REQ-026 flush in CALC or FIX: next state IDLE, hi/lo unchanged, no done pulse.
REQ-027 flush in IDLE or DONE: no effect; commit in DONE stands.
REQ-028 flush and start together in IDLE: start ignored.
REQ-029 wrLo/wrHi: honored only when busy=0; each updates its register at next edge.
REQ-030 wrLo/wrHi while busy=1: ignored (the hazard unit stalls MT* behind busy).
REQ-031 start with wrLo/wrHi in IDLE: write applied and op started; the later op result overwrites both.

Reset
REQ-032 rst_n low: FSM=IDLE, counter=0, hi=lo=0, busy=done=writeLoHi=0, immediately and asynchronously.
REQ-033 Reset mid-op: result discarded, no done pulse after release.

Structure
REQ-034 Op encodings (MULT/MULTU/DIV/DIVU) and FSM state constants SHALL live in the shared ISA header, beside the existing instruction-field macros.
REQ-035 Single module, no sub-module; one shared WIDTH+1-bit adder/subtractor serves both multiply and divide.

Verification
REQ-036 MULT 0xFFFFFFFF x 0x00000002 -> done at cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-038 start MULTU 3x5, flush at cycle 10 -> busy=0 at cycle 11, no done, hi/lo hold prior values; a second start also issued at cycle 10 is ignored.
REQ-039 wrLo=1, wrData=0x12345678 while busy -> lo unchanged; same write in IDLE -> lo=0x12345678 next cycle.
REQ-040 rst_n pulsed low at cycle 20 of a DIV -> all outputs 0 immediately; no done after release; a new start then completes normally.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared ISA header: instruction-field constants plus the HI/LO unit's
// operation encodings, FSM states and small decode helpers.
package mult_div_unit_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdState_t;

  function automatic logic opSigned(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic opIsDiv(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over one shared adder/subtractor, plus MTHI/MTLO writes.
//
// state | meaning
// IDLE  | waiting for start; MT writes accepted
// CALC  | one radix-2 step per cycle, WIDTH cycles
// FIX   | phase 0 applies sign correction, phase 1 commits hi/lo
// DONE  | done pulse, results visible; MT writes accepted
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  input  logic             wrLo,
  input  logic             wrHi,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic             writeLoHi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mdState_t          state;
  logic [CNT_W-1:0]  cnt;
  logic              fixPh;
  logic [WIDTH-1:0]  accHi, accLo, opnd;
  logic              isDiv, negQ, negR, divZero;

  logic [WIDTH:0]    addA, addB, multSum;
  logic              addSub;
  logic [WIDTH+1:0]  addSum;
  logic              divGe;
  logic              aNeg, bNeg;
  logic [WIDTH-1:0]  absA, absB;
  logic [2*WIDTH-1:0] prodNeg;

  // Divide: carry out of shifted-remainder minus divisor means "fits".
  always_comb begin
    addA   = {1'b0, accHi};
    addB   = {1'b0, opnd};
    addSub = 1'b0;
    if (isDiv) begin
      addA   = {accHi, accLo[WIDTH-1]};
      addSub = 1'b1;
    end
    addSum  = {1'b0, addA} + {1'b0, addB ^ {(WIDTH+1){addSub}}}
            + {{(WIDTH+1){1'b0}}, addSub};
    divGe   = addSum[WIDTH+1];
    multSum = accLo[0] ? addSum[WIDTH:0] : {1'b0, accHi};
  end

  always_comb begin
    aNeg    = opSigned(op) & srcA[WIDTH-1];
    bNeg    = opSigned(op) & srcB[WIDTH-1];
    absA    = aNeg ? -srcA : srcA;
    absB    = bNeg ? -srcB : srcB;
    prodNeg = -{accHi, accLo};
  end

  assign writeLoHi = done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      fixPh   <= 1'b0;
      accHi   <= '0;
      accLo   <= '0;
      opnd    <= '0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (!busy && wrLo) lo <= wrData;
      if (!busy && wrHi) hi <= wrData;

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            state   <= CALC;
            busy    <= 1'b1;
            cnt     <= '0;
            fixPh   <= 1'b0;
            isDiv   <= opIsDiv(op);
            negQ    <= aNeg ^ bNeg;
            negR    <= aNeg;
            divZero <= opIsDiv(op) && (srcB == '0);
            accHi   <= '0;
            accLo   <= opIsDiv(op) ? absA : absB;
            opnd    <= opIsDiv(op) ? absB : absA;
          end
        end

        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (isDiv) begin
              accHi <= divGe ? addSum[WIDTH-1:0] : addA[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], divGe};
            end else begin
              accHi <= multSum[WIDTH:1];
              accLo <= {multSum[0], accLo[WIDTH-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_STEP) state <= FIX;
          end
        end

        FIX: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!fixPh) begin
            fixPh <= 1'b1;
            if (!isDiv) begin
              if (negQ) {accHi, accLo} <= prodNeg;
            end else begin
              // Divide-by-zero keeps the all-ones quotient regardless of sign.
              if (negQ && !divZero) accLo <= prodNeg[WIDTH-1:0];
              if (negR) accHi <= -accHi;
            end
          end else begin
            hi    <= accHi;
            lo    <= accLo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency, flush,
// MTHI/MTLO writes and asynchronous reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA, srcB;
  logic        flush;
  logic        wrLo, wrHi;
  logic [31:0] wrData;
  logic        busy, done, writeLoHi;
  logic [31:0] lo, hi;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .flush(flush), .wrLo(wrLo), .wrHi(wrHi), .wrData(wrData),
    .busy(busy), .done(done), .writeLoHi(writeLoHi), .lo(lo), .hi(hi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srcA = a; srcB = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    flush = 1'b0; wrLo = 1'b0; wrHi = 1'b0; wrData = '0;
    #2;
    total++;
    if ({busy, done, writeLoHi} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, writeLoHi});
    end
    total++;
    if ({hi, lo} !== 64'h0) begin
      bad++; $display("FAIL reset_hilo got=%h want=0", {hi, lo});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    logic [1:0]  vOp [4] = '{2'b00, 2'b01, 2'b00, 2'b00};
    logic [31:0] vA  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFD};
    logic [31:0] vB  [4] = '{32'h00000002, 32'h00000002, 32'h7FFFFFFF, 32'hFFFFFFFB};
    logic [31:0] eHi [4] = '{32'hFFFFFFFF, 32'h00000001, 32'h3FFFFFFF, 32'h00000000};
    logic [31:0] eLo [4] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000001, 32'h0000000F};
    int lat;
    for (int k = 0; k < 4; k++) begin
      issue(vOp[k], vA[k], vB[k]);
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL mult_busy[%0d] got=%b want=1", k, busy);
      end
      waitDone(lat);
      total++;
      if (lat !== 34) begin
        bad++; $display("FAIL mult_latency[%0d] got=%0d want=34", k, lat);
      end
      total++;
      if ({hi, lo} !== {eHi[k], eLo[k]}) begin
        bad++; $display("FAIL mult_result[%0d] got=%h_%h want=%h_%h", k, hi, lo, eHi[k], eLo[k]);
      end
      total++;
      if ({writeLoHi, busy} !== 2'b10) begin
        bad++; $display("FAIL mult_done_flags[%0d] got=%b want=10", k, {writeLoHi, busy});
      end
      tick();
      total++;
      if (done !== 1'b0) begin
        bad++; $display("FAIL mult_done_pulse[%0d] got=%b want=0", k, done);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0]  vOp [6] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [31:0] vA  [6] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000,
                             32'h00000007, 32'hFFFFFFF8, 32'hFFFFFFFF};
    logic [31:0] vB  [6] = '{32'h00000002, 32'h00000000, 32'hFFFFFFFF,
                             32'hFFFFFFFE, 32'h00000000, 32'h00000010};
    logic [31:0] eHi [6] = '{32'hFFFFFFFF, 32'h00000007, 32'h00000000,
                             32'h00000001, 32'hFFFFFFF8, 32'h0000000F};
    logic [31:0] eLo [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                             32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0FFFFFFF};
    int lat;
    for (int k = 0; k < 6; k++) begin
      issue(vOp[k], vA[k], vB[k]);
      waitDone(lat);
      total++;
      if (lat !== 34) begin
        bad++; $display("FAIL div_latency[%0d] got=%0d want=34", k, lat);
      end
      total++;
      if ({hi, lo} !== {eHi[k], eLo[k]}) begin
        bad++; $display("FAIL div_result[%0d] got=%h_%h want=%h_%h", k, hi, lo, eHi[k], eLo[k]);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    wrLo = 1'b1; wrHi = 1'b1; wrData = 32'hAAAA5555;
    tick();
    wrLo = 1'b0; wrHi = 1'b0;
    issue(2'b01, 32'd3, 32'd5);
    repeat (9) tick();
    flush = 1'b1; start = 1'b1; op = 2'b00;
    tick();
    flush = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL flush_busy got=%b want=0", busy);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL flush_no_done got=%0d want=0", seen);
    end
    total++;
    if ({hi, lo} !== {32'hAAAA5555, 32'hAAAA5555}) begin
      bad++; $display("FAIL flush_hold got=%h_%h want=aaaa5555_aaaa5555", hi, lo);
    end
    // flush with start in IDLE: start dropped
    flush = 1'b1; start = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL flush_start_idle got=%b want=0", busy);
    end
    // flush during DONE leaves the commit in place
    issue(2'b01, 32'd3, 32'd5);
    waitDone(lat);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if ({hi, lo} !== {32'h0, 32'h0000000F}) begin
      bad++; $display("FAIL flush_in_done got=%h_%h want=00000000_0000000f", hi, lo);
    end
  endtask

  task automatic test_write();
    int lat;
    issue(2'b01, 32'd6, 32'd7);
    wrLo = 1'b1; wrHi = 1'b1; wrData = 32'h12345678;
    tick();
    wrLo = 1'b0; wrHi = 1'b0;
    total++;
    if ({hi, lo} !== {32'h0, 32'h0000000F}) begin
      bad++; $display("FAIL write_busy got=%h_%h want=00000000_0000000f", hi, lo);
    end
    waitDone(lat);
    total++;
    if ({hi, lo} !== {32'h0, 32'd42}) begin
      bad++; $display("FAIL write_busy_result got=%h_%h want=00000000_0000002a", hi, lo);
    end
    tick();
    wrLo = 1'b1; wrData = 32'h12345678;
    tick();
    wrLo = 1'b0;
    total++;
    if ({hi, lo} !== {32'h0, 32'h12345678}) begin
      bad++; $display("FAIL write_lo_idle got=%h_%h want=00000000_12345678", hi, lo);
    end
    wrHi = 1'b1; wrData = 32'hCAFEBABE;
    tick();
    wrHi = 1'b0;
    total++;
    if ({hi, lo} !== {32'hCAFEBABE, 32'h12345678}) begin
      bad++; $display("FAIL write_hi_idle got=%h_%h want=cafebabe_12345678", hi, lo);
    end
    // start together with MTLO: write lands now, result overwrites later
    wrLo = 1'b1; wrData = 32'h0BADF00D;
    issue(2'b11, 32'd100, 32'd7);
    wrLo = 1'b0;
    total++;
    if (lo !== 32'h0BADF00D) begin
      bad++; $display("FAIL write_with_start got=%h want=0badf00d", lo);
    end
    waitDone(lat);
    total++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      bad++; $display("FAIL write_overwritten got=%h_%h want=00000002_0000000e", hi, lo);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    int lat;
    int seen;
    issue(2'b10, 32'd1000, 32'd3);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, writeLoHi} !== 3'b000) begin
      bad++; $display("FAIL midreset_flags got=%b want=000", {busy, done, writeLoHi});
    end
    total++;
    if ({hi, lo} !== 64'h0) begin
      bad++; $display("FAIL midreset_hilo got=%h want=0", {hi, lo});
    end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL midreset_no_done got=%0d want=0", seen);
    end
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    waitDone(lat);
    total++;
    if (lat !== 34 || {hi, lo} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      bad++; $display("FAIL midreset_recover got=%0d %h_%h want=34 ffffffff_fffffffd", lat, hi, lo);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'b01, 32'd9, 32'd9);
    waitDone(lat);
    op = 2'b00; srcA = 32'hFFFFFFFF; srcB = 32'hFFFFFFFF; start = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_start_in_done got=%b want=0", busy);
    end
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL b2b_start_idle got=%b want=1", busy);
    end
    op = 2'b11; srcA = 32'd50; srcB = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(lat);
    total++;
    if (lat !== 33 || {hi, lo} !== {32'h0, 32'h1}) begin
      bad++; $display("FAIL b2b_result got=%0d %h_%h want=33 00000000_00000001", lat, hi, lo);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_write();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
